// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and AXI constants for the CPU-to-AXI3 bridge.
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_RESP
  } state_t;

  typedef enum logic {
    OWN_INST,
    OWN_DATA
  } owner_t;

  localparam logic [2:0] SIZE_WORD   = 3'd2;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [3:0] LEN_SINGLE  = 4'd0;
  localparam logic [3:0] DEF_ID_INST = 4'd0;
  localparam logic [3:0] DEF_ID_DATA = 4'd1;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// CPU SRAM-like port pair and AXI3 single-beat master port.
interface cpu_sram_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output inst_req, inst_addr, data_req, data_wr, data_wen, data_addr, data_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata
  );
  modport slave (
    input  inst_req, inst_addr, data_req, data_wr, data_wen, data_addr, data_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata
  );
endinterface

interface cpu_axi_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
           awid, awaddr, awlen, awsize, awburst, awvalid,
           wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rvalid, awready, wready, bvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
           awid, awaddr, awlen, awsize, awburst, awvalid,
           wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// Arbitrates CPU instruction/data SRAM-like ports onto one AXI3 master,
// data first, one transaction outstanding.
module cpu_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter logic [3:0] ID_INST = DEF_ID_INST,
  parameter logic [3:0] ID_DATA = DEF_ID_DATA
) (
  input  logic       clk,
  input  logic       rst,
  cpu_sram_if.slave  cpu,
  cpu_axi_if.master  axi
);

  state_t      r_state;
  owner_t      r_owner;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic        r_aw_done, r_w_done;
  logic        r_inst_data_ok, r_data_data_ok;
  logic [31:0] r_inst_rdata, r_data_rdata;

  logic        w_idle, w_accept_data, w_accept_inst;
  logic        w_aw_hs, w_w_hs;
  logic        w_unused_rid;

  assign w_idle        = (r_state == S_IDLE);
  assign w_accept_data = w_idle & cpu.data_req;
  assign w_accept_inst = w_idle & cpu.inst_req & ~cpu.data_req;
  assign w_aw_hs       = r_awvalid & axi.awready;
  assign w_w_hs        = r_wvalid & axi.wready;
  assign w_unused_rid  = ^axi.rid;

  assign cpu.inst_addr_ok = w_accept_inst;
  assign cpu.data_addr_ok = w_accept_data;
  assign cpu.inst_data_ok = r_inst_data_ok;
  assign cpu.data_data_ok = r_data_data_ok;
  assign cpu.inst_rdata   = r_inst_rdata;
  assign cpu.data_rdata   = r_data_rdata;

  assign axi.arid    = (r_owner == OWN_DATA) ? ID_DATA : ID_INST;
  assign axi.araddr  = r_addr;
  assign axi.arlen   = LEN_SINGLE;
  assign axi.arsize  = SIZE_WORD;
  assign axi.arburst = BURST_INCR;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;
  assign axi.awid    = ID_DATA;
  assign axi.awaddr  = r_addr;
  assign axi.awlen   = LEN_SINGLE;
  assign axi.awsize  = SIZE_WORD;
  assign axi.awburst = BURST_INCR;
  assign axi.awvalid = r_awvalid;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = r_wvalid;
  assign axi.bready  = r_bready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_owner        <= OWN_INST;
      r_addr         <= '0;
      r_wstrb        <= '0;
      r_wdata        <= '0;
      r_arvalid      <= 1'b0;
      r_rready       <= 1'b0;
      r_awvalid      <= 1'b0;
      r_wvalid       <= 1'b0;
      r_bready       <= 1'b0;
      r_aw_done      <= 1'b0;
      r_w_done       <= 1'b0;
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
      r_inst_rdata   <= '0;
      r_data_rdata   <= '0;
    end else begin
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept_data) begin
            r_owner <= OWN_DATA;
            r_addr  <= word_align(cpu.data_addr);
            r_wstrb <= cpu.data_wen;
            r_wdata <= cpu.data_wdata;
            if (cpu.data_wr) begin
              r_state   <= S_WR_ADDR;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_state   <= S_RD_ADDR;
              r_arvalid <= 1'b1;
            end
          end else if (w_accept_inst) begin
            r_owner   <= OWN_INST;
            r_addr    <= word_align(cpu.inst_addr);
            r_state   <= S_RD_ADDR;
            r_arvalid <= 1'b1;
          end
        end
        S_RD_ADDR: begin
          if (axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (axi.rvalid) begin
            r_rready <= 1'b0;
            r_state  <= S_IDLE;
            if (r_owner == OWN_DATA) begin
              r_data_rdata   <= axi.rdata;
              r_data_data_ok <= 1'b1;
            end else begin
              r_inst_rdata   <= axi.rdata;
              r_inst_data_ok <= 1'b1;
            end
          end
        end
        S_WR_ADDR: begin
          // AW and W retire independently; leave once both have, possibly in the same cycle.
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (axi.bvalid) begin
            r_bready       <= 1'b0;
            r_data_data_ok <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
